// File: rtl/pgm_sound_pkg.sv
// Shared constants and types for the 68k <-> Z80 sound mailbox.
// Covers the 68k word indices, the Z80 I/O pages, the control magic words and the FSM encodings.
package pgm_sound_pkg;

    localparam logic [2:0] IDX_CMD    = 3'd1;
    localparam logic [2:0] IDX_LATCH2 = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd4;
    localparam logic [2:0] IDX_LATCH3 = 3'd6;

    localparam logic [7:0] PAGE_LATCH3 = 8'h81;
    localparam logic [7:0] PAGE_CMD    = 8'h82;
    localparam logic [7:0] PAGE_LATCH2 = 8'h84;

    localparam logic [15:0] CTRL_RESET = 16'h5050;
    localparam logic [15:0] CTRL_HALT  = 16'h45D3;

    // The encoding is visible to the 68k through the status word.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StReset = 2'd1,
        StHalt  = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        NmiIdle = 2'd0,
        NmiLow  = 2'd1,
        NmiGap  = 2'd2
    } nmi_phase_e;

    function automatic logic [15:0] status_word(input ctrl_state_e st, input logic nmi_act,
                                                input logic q3, input logic q2, input logic p1);
        return {10'b0, st, nmi_act, q3, q2, p1};
    endfunction

endpackage

// File: rtl/pgm_nmi_pulser.sv
// Z80 NMI pulse generator: fixed-length low pulse, enforced high gap and a one-deep retrigger queue.
module pgm_nmi_pulser
    import pgm_sound_pkg::*;
#(
    parameter int unsigned NMI_CYCLES = 16,
    parameter int unsigned NMI_GAP    = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic trigger_i,
    input  logic enable_i,
    input  logic flush_i,
    output logic nmi_no,
    output logic active_o
);

    localparam int unsigned CntMax = (NMI_CYCLES > NMI_GAP) ? NMI_CYCLES : NMI_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    nmi_phase_e      phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            queue_q, queue_d;
    logic            fire;

    assign fire = trigger_i & enable_i;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        queue_d = queue_q;
        if (flush_i) begin
            phase_d = NmiIdle;
            cnt_d   = '0;
            queue_d = 1'b0;
        end else begin
            case (phase_q)
                NmiIdle: begin
                    if (fire) begin
                        phase_d = NmiLow;
                        cnt_d   = CntW'(NMI_CYCLES);
                    end
                end
                NmiLow: begin
                    if (fire) begin
                        queue_d = 1'b1;
                    end
                    if (cnt_q == CntW'(1)) begin
                        phase_d = NmiGap;
                        cnt_d   = CntW'(NMI_GAP);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                NmiGap: begin
                    // A trigger in the last gap cycle starts the next pulse directly.
                    if (cnt_q == CntW'(1)) begin
                        if (queue_q || fire) begin
                            phase_d = NmiLow;
                            cnt_d   = CntW'(NMI_CYCLES);
                            queue_d = 1'b0;
                        end else begin
                            phase_d = NmiIdle;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                        if (fire) begin
                            queue_d = 1'b1;
                        end
                    end
                end
                default: begin
                    phase_d = NmiIdle;
                    cnt_d   = '0;
                    queue_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= NmiIdle;
            cnt_q   <= '0;
            queue_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            queue_q <= queue_d;
        end
    end

    assign nmi_no   = (phase_q != NmiLow);
    assign active_o = (phase_q != NmiIdle);

endmodule

// File: rtl/pgm_sound_mailbox.sv
// 68k <-> Z80 sound-latch mailbox: command/reply latches, handshake flags, Z80 reset/halt
// control and NMI generation towards the sound CPU.
module pgm_sound_mailbox
    import pgm_sound_pkg::*;
#(
    parameter int unsigned NMI_CYCLES   = 16,
    parameter int unsigned NMI_GAP      = 4,
    parameter int unsigned RESET_CYCLES = 64
) (
    input  logic        fixed_20m_clk,
    input  logic        reset,
    input  logic        m_we,
    input  logic        m_re,
    input  logic [2:0]  m_idx,
    input  logic [1:0]  m_be,
    input  logic [15:0] m_din,
    output logic [15:0] m_dout,
    output logic        m_ack,
    input  logic        z_wr,
    input  logic        z_rd,
    input  logic [7:0]  z_page,
    input  logic [7:0]  z_din,
    output logic [7:0]  z_dout,
    output logic        z80_reset,
    output logic        z80_busrq_n,
    output logic        z80_nmi_n
);

    localparam int unsigned RstW = $clog2(RESET_CYCLES + 1);

    ctrl_state_e     state_q, state_d;
    logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]      c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [7:0]      r2_q, r2_d, r3_q, r3_d;
    logic            p1_q, p1_d, q2_q, q2_d, q3_q, q3_d;
    logic            m_ack_q;
    logic [15:0]     m_dout_q, m_dout_d;
    logic [15:0]     rd_data;

    logic ctrl_wr, c1_wr, c2_wr, c3_wr;
    logic m_rd_r2, m_rd_r3;
    logic z_rd_c1, z_wr_r2, z_wr_r3;
    logic reset_entry;
    logic nmi_active;

    assign ctrl_wr = m_we & (m_idx == IDX_CTRL) & (m_be == 2'b11);
    assign c1_wr   = m_we & (m_idx == IDX_CMD) & m_be[0];
    assign c2_wr   = m_we & (m_idx == IDX_LATCH2) & m_be[0];
    assign c3_wr   = m_we & (m_idx == IDX_LATCH3) & m_be[0];
    assign m_rd_r2 = m_re & (m_idx == IDX_LATCH2);
    assign m_rd_r3 = m_re & (m_idx == IDX_LATCH3);
    assign z_rd_c1 = z_rd & (z_page == PAGE_CMD);
    assign z_wr_r2 = z_wr & (z_page == PAGE_LATCH2);
    assign z_wr_r3 = z_wr & (z_page == PAGE_LATCH3);

    // Control FSM: a reset command always (re)loads the reset-length counter.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            StRun: begin
                if (ctrl_wr && m_din == CTRL_RESET) begin
                    state_d   = StReset;
                    rst_cnt_d = RstW'(RESET_CYCLES);
                end else if (ctrl_wr && m_din == CTRL_HALT) begin
                    state_d = StHalt;
                end
            end
            StReset: begin
                if (ctrl_wr && m_din == CTRL_RESET) begin
                    rst_cnt_d = RstW'(RESET_CYCLES);
                end else if (rst_cnt_q == RstW'(1)) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q - RstW'(1);
                end
            end
            StHalt: begin
                if (ctrl_wr) begin
                    if (m_din == CTRL_RESET) begin
                        state_d   = StReset;
                        rst_cnt_d = RstW'(RESET_CYCLES);
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d   = StRun;
                rst_cnt_d = '0;
            end
        endcase
    end

    assign reset_entry = (state_d == StReset) && (state_q != StReset);

    // Setting a flag wins over clearing it in the same cycle; entering reset wins over both.
    always_comb begin
        c1_d = c1_wr ? m_din[7:0] : c1_q;
        c2_d = c2_wr ? m_din[7:0] : c2_q;
        c3_d = c3_wr ? m_din[7:0] : c3_q;
        r2_d = z_wr_r2 ? z_din : r2_q;
        r3_d = z_wr_r3 ? z_din : r3_q;

        p1_d = p1_q;
        if (c1_wr) begin
            p1_d = 1'b1;
        end else if (z_rd_c1) begin
            p1_d = 1'b0;
        end

        q2_d = q2_q;
        if (z_wr_r2) begin
            q2_d = 1'b1;
        end else if (m_rd_r2) begin
            q2_d = 1'b0;
        end

        q3_d = q3_q;
        if (z_wr_r3) begin
            q3_d = 1'b1;
        end else if (m_rd_r3) begin
            q3_d = 1'b0;
        end

        if (reset_entry) begin
            p1_d = 1'b0;
            q2_d = 1'b0;
            q3_d = 1'b0;
        end
    end

    always_comb begin
        rd_data = 16'hFFFF;
        case (m_idx)
            IDX_LATCH2: rd_data = {8'h00, r2_q};
            IDX_LATCH3: rd_data = {8'h00, r3_q};
            IDX_CTRL:   rd_data = status_word(state_q, nmi_active, q3_q, q2_q, p1_q);
            default:    rd_data = 16'hFFFF;
        endcase
        m_dout_d = m_re ? rd_data : m_dout_q;
    end

    always_comb begin
        z_dout = 8'hFF;
        case (z_page)
            PAGE_CMD:    z_dout = c1_q;
            PAGE_LATCH2: z_dout = c2_q;
            PAGE_LATCH3: z_dout = c3_q;
            default:     z_dout = 8'hFF;
        endcase
    end

    pgm_nmi_pulser #(
        .NMI_CYCLES (NMI_CYCLES),
        .NMI_GAP    (NMI_GAP)
    ) u_nmi_pulser (
        .clk_i     (fixed_20m_clk),
        .reset_i   (reset),
        .trigger_i (c1_wr),
        .enable_i  (state_d == StRun),
        .flush_i   (reset_entry),
        .nmi_no    (z80_nmi_n),
        .active_o  (nmi_active)
    );

    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            state_q   <= StRun;
            rst_cnt_q <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            c3_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            p1_q      <= 1'b0;
            q2_q      <= 1'b0;
            q3_q      <= 1'b0;
            m_ack_q   <= 1'b0;
            m_dout_q  <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            c3_q      <= c3_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
            p1_q      <= p1_d;
            q2_q      <= q2_d;
            q3_q      <= q3_d;
            m_ack_q   <= m_we | m_re;
            m_dout_q  <= m_dout_d;
        end
    end

    assign m_ack       = m_ack_q;
    assign m_dout      = m_dout_q;
    assign z80_reset   = (state_q == StReset);
    assign z80_busrq_n = (state_q != StHalt);

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Bench for pgm_sound_mailbox: directed scenarios plus random traffic, all checked every cycle
// against a timeline model (absolute pulse start times and reset deadlines).
module tb_pgm_sound_mailbox;

    localparam int NC = 16;
    localparam int NG = 4;
    localparam int RC = 64;
    localparam int NP = NC + NG;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_we, m_re;
    logic [2:0]  m_idx;
    logic [1:0]  m_be;
    logic [15:0] m_din, m_dout;
    logic        m_ack;
    logic        z_wr, z_rd;
    logic [7:0]  z_page, z_din, z_dout;
    logic        z80_reset, z80_busrq_n, z80_nmi_n;

    always #5 clk = ~clk;

    pgm_sound_mailbox #(
        .NMI_CYCLES   (NC),
        .NMI_GAP      (NG),
        .RESET_CYCLES (RC)
    ) dut (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .m_we          (m_we),
        .m_re          (m_re),
        .m_idx         (m_idx),
        .m_be          (m_be),
        .m_din         (m_din),
        .m_dout        (m_dout),
        .m_ack         (m_ack),
        .z_wr          (z_wr),
        .z_rd          (z_rd),
        .z_page        (z_page),
        .z_din         (z_din),
        .z_dout        (z_dout),
        .z80_reset     (z80_reset),
        .z80_busrq_n   (z80_busrq_n),
        .z80_nmi_n     (z80_nmi_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: ms 0=run 1=reset 2=halt; NMI pulses occupy [cur_s, cur_s+NP).
    int          t = 0;
    int          ms = 0;
    int          rst_until = 0;
    int          cur_s = -1000;
    bit          pend = 0;
    logic [7:0]  c1 = 0, c2 = 0, c3 = 0, r2 = 0, r3 = 0;
    logic        p1 = 0, q2 = 0, q3 = 0;
    logic        exp_ack = 0;
    logic [15:0] exp_dout = 0;

    logic        last_ack, last_nmi, last_rst, last_busrq;
    logic [15:0] last_dout;
    logic [7:0]  last_zdout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [7:0] zmap(input logic [7:0] pg);
        case (pg)
            8'h82:   return c1;
            8'h84:   return c2;
            8'h81:   return c3;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic step(input logic we, input logic re, input logic [2:0] idx,
                        input logic [1:0] be, input logic [15:0] din, input logic zw,
                        input logic zr, input logic [7:0] pg, input logic [7:0] zd);
        logic        act, low;
        logic [15:0] rdval;
        int          nxt;
        bit          entry, ctrl;
        @(negedge clk);
        if (pend && t == cur_s + NP) begin
            cur_s = cur_s + NP;
            pend  = 0;
        end
        act = (cur_s <= t) && (t < cur_s + NP);
        low = (cur_s <= t) && (t < cur_s + NC);
        last_ack   = m_ack;
        last_dout  = m_dout;
        last_nmi   = z80_nmi_n;
        last_rst   = z80_reset;
        last_busrq = z80_busrq_n;
        check_eq("z80_nmi_n", last_nmi, !low);
        check_eq("z80_reset", last_rst, ms == 1);
        check_eq("z80_busrq_n", last_busrq, ms != 2);
        check_eq("m_ack", last_ack, exp_ack);
        if (exp_ack) check_eq("m_dout", last_dout, exp_dout);

        m_we = we; m_re = re; m_idx = idx; m_be = be; m_din = din;
        z_wr = zw; z_rd = zr; z_page = pg; z_din = zd;
        #1;
        last_zdout = z_dout;
        check_eq("z_dout", last_zdout, zmap(pg));

        case (idx)
            3'd2:    rdval = {8'h00, r2};
            3'd6:    rdval = {8'h00, r3};
            3'd4:    rdval = {10'b0, 2'(ms), act, q3, q2, p1};
            default: rdval = 16'hFFFF;
        endcase
        exp_ack = we | re;
        if (re) exp_dout = rdval;

        ctrl  = we && idx == 3'd4 && be == 2'b11;
        nxt   = ms;
        entry = 0;
        case (ms)
            0: if (ctrl) begin
                if (din == 16'h5050) begin nxt = 1; rst_until = t + RC; entry = 1; end
                else if (din == 16'h45D3) nxt = 2;
            end
            1: if (ctrl && din == 16'h5050) rst_until = t + RC;
               else if (t >= rst_until) nxt = 0;
            default: if (ctrl) begin
                if (din == 16'h5050) begin nxt = 1; rst_until = t + RC; entry = 1; end
                else nxt = 0;
            end
        endcase

        if (zr && pg == 8'h82) p1 = 0;
        if (re && idx == 3'd2) q2 = 0;
        if (re && idx == 3'd6) q3 = 0;
        if (zw && pg == 8'h84) begin r2 = zd; q2 = 1; end
        if (zw && pg == 8'h81) begin r3 = zd; q3 = 1; end
        if (we && be[0]) begin
            if (idx == 3'd1) begin
                c1 = din[7:0];
                p1 = 1;
                if (nxt == 0) begin
                    if (act) pend = 1;
                    else cur_s = t + 1;
                end
            end
            if (idx == 3'd2) c2 = din[7:0];
            if (idx == 3'd6) c3 = din[7:0];
        end
        if (entry) begin
            p1 = 0; q2 = 0; q3 = 0;
            cur_s = -1000;
            pend  = 0;
        end
        ms = nxt;
        t++;
    endtask

    task automatic idle();
        step(0, 0, 3'd0, 2'b00, 16'h0, 0, 0, 8'h00, 8'h00);
    endtask
    task automatic wr68(input logic [2:0] idx, input logic [1:0] be, input logic [15:0] d);
        step(1, 0, idx, be, d, 0, 0, 8'h00, 8'h00);
    endtask
    task automatic rd68(input logic [2:0] idx);
        step(0, 1, idx, 2'b11, 16'h0, 0, 0, 8'h00, 8'h00);
    endtask
    task automatic zwrite(input logic [7:0] pg, input logic [7:0] d);
        step(0, 0, 3'd0, 2'b00, 16'h0, 1, 0, pg, d);
    endtask
    task automatic zread(input logic [7:0] pg);
        step(0, 0, 3'd0, 2'b00, 16'h0, 0, 1, pg, 8'h00);
    endtask

    task automatic rand_step();
        logic        we, re, zw, zr;
        logic [2:0]  idx;
        logic [1:0]  be;
        logic [15:0] din;
        logic [7:0]  pg;
        int          r, k;
        r   = int'($urandom_range(0, 99));
        we  = r < 20;
        re  = r >= 20 && r < 35;
        idx = 3'($urandom_range(0, 7));
        be  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        din = 16'($urandom);
        if (we && idx == 3'd4) begin
            k = int'($urandom_range(0, 9));
            if (k < 2) din = 16'h5050;
            else if (k < 5) din = 16'h45D3;
        end
        r  = int'($urandom_range(0, 99));
        zw = r < 10;
        zr = r >= 10 && r < 25;
        case ($urandom_range(0, 3))
            0:       pg = 8'h81;
            1:       pg = 8'h82;
            2:       pg = 8'h84;
            default: pg = 8'($urandom);
        endcase
        step(we, re, idx, be, din, zw, zr, pg, 8'($urandom));
    endtask

    initial begin
        int cnt, first, lastv, nst;
        int st[3];
        logic prev;

        reset = 1;
        m_we = 0; m_re = 0; m_idx = 0; m_be = 0; m_din = 0;
        z_wr = 0; z_rd = 0; z_page = 0; z_din = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;

        idle();
        check_eq("rst_m_ack", last_ack, 1'b0);
        check_eq("rst_m_dout", last_dout, 16'h0000);
        check_eq("rst_z80_reset", last_rst, 1'b0);
        check_eq("rst_busrq_n", last_busrq, 1'b1);
        check_eq("rst_nmi_n", last_nmi, 1'b1);

        // Single command: pulse shape, status during the pulse, Z80 handshake.
        wr68(3'd1, 2'b11, 16'h0037);
        cnt = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3 || i == 27) rd68(3'd4);
            else if (i == 25) zread(8'h82);
            else idle();
            if (!last_nmi) begin cnt++; if (first < 0) first = i; end
            if (i == 4) check_eq("status_pulse", last_dout, 16'h0009);
            if (i == 25) check_eq("z_cmd_read", last_zdout, 8'h37);
            if (i == 28) check_eq("status_idle", last_dout, 16'h0000);
        end
        check_eq("nmi_len", cnt, NC);
        check_eq("nmi_first", first, 1);

        // Queued and merged retriggers.
        cnt = 0; nst = 0; prev = 1'b1;
        st[0] = -1; st[1] = -1; st[2] = -1;
        for (int i = 0; i <= 70; i++) begin
            if (i == 0 || i == 3 || i == 25) wr68(3'd1, 2'b11, 16'h00C0 + 16'(i));
            else idle();
            if (!last_nmi) cnt++;
            if (prev && !last_nmi) begin
                if (nst < 3) st[nst] = i;
                nst++;
            end
            prev = last_nmi;
        end
        check_eq("nmi_pulses", nst, 3);
        check_eq("nmi_start0", st[0], 1);
        check_eq("nmi_start1", st[1], 1 + NP);
        check_eq("nmi_start2", st[2], 1 + 2 * NP);
        check_eq("nmi_low_total", cnt, 3 * NC);

        // Z80 reply through latch2.
        zwrite(8'h84, 8'hA5);
        rd68(3'd4);
        rd68(3'd2);
        check_eq("q2_set", last_dout[1], 1'b1);
        idle();
        check_eq("r2_read", last_dout, 16'h00A5);
        check_eq("r2_ack", last_ack, 1'b1);
        rd68(3'd4);
        idle();
        check_eq("q2_clr", last_dout[1], 1'b0);

        // Reset command: length, flag clear, no NMI inside the window.
        zwrite(8'h84, 8'h11);
        zwrite(8'h81, 8'h22);
        wr68(3'd4, 2'b11, 16'h5050);
        cnt = 0; first = -1; lastv = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 2) rd68(3'd4);
            else if (i == 10) wr68(3'd1, 2'b11, 16'h0055);
            else idle();
            if (last_rst) begin cnt++; if (first < 0) first = i; end
            if (!last_nmi) lastv++;
            if (i == 3) check_eq("rst_flags", last_dout, 16'h0010);
        end
        check_eq("rst_len", cnt, RC);
        check_eq("rst_first", first, 1);
        check_eq("rst_no_nmi", lastv, 0);

        // Reset command rewritten at cycle 30 extends the window.
        wr68(3'd4, 2'b11, 16'h5050);
        cnt = 0; lastv = -1;
        for (int i = 1; i <= 110; i++) begin
            if (i == 30) wr68(3'd4, 2'b11, 16'h5050);
            else idle();
            if (last_rst) begin cnt++; lastv = i; end
        end
        check_eq("rst_ext_len", cnt, 30 + RC);
        check_eq("rst_ext_last", lastv, 30 + RC);

        // Halt: byte write ignored, full write releases.
        wr68(3'd4, 2'b11, 16'h45D3);
        idle();
        check_eq("halt_busrq", last_busrq, 1'b0);
        wr68(3'd4, 2'b01, 16'h0000);
        idle();
        check_eq("halt_byte_wr", last_busrq, 1'b0);
        wr68(3'd4, 2'b11, 16'h0000);
        idle();
        check_eq("halt_release", last_busrq, 1'b1);

        // Same-cycle c1 write and Z80 read; unmapped index.
        wr68(3'd1, 2'b11, 16'h0022);
        repeat (25) idle();
        step(1, 0, 3'd1, 2'b11, 16'h0011, 0, 1, 8'h82, 8'h00);
        check_eq("z_old_c1", last_zdout, 8'h22);
        rd68(3'd4);
        idle();
        check_eq("p1_kept", last_dout[0], 1'b1);
        rd68(3'd3);
        idle();
        check_eq("unmapped_rd", last_dout, 16'hFFFF);
        check_eq("unmapped_ack", last_ack, 1'b1);

        for (int i = 0; i < 3000; i++) rand_step();
        repeat (2) idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
